// File: rtl/riscv_divider.sv
// Multi-cycle radix-2 restoring divider for RV64M (DIV/DIVU/REM/REMU and W variants).
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module riscv_divider #(
    parameter int XLEN = 64
) (
    input  logic            i_riscv_div_clk,
    input  logic            i_riscv_div_rst,
    input  logic            i_riscv_div_en,
    input  logic [2:0]      i_riscv_div_ctrl,
    input  logic [XLEN-1:0] i_riscv_div_rs1data,
    input  logic [XLEN-1:0] i_riscv_div_rs2data,
    input  logic            i_riscv_div_stallother,
    input  logic            i_riscv_div_kill,
    output logic [XLEN-1:0] o_riscv_div_result,
    output logic            o_riscv_div_valid,
    output logic            o_riscv_div_busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] N_FULL = CW'(XLEN);
    localparam logic [CW-1:0] N_WORD = CW'(32);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_word;
    logic            r_rem_sel;
    logic [XLEN-1:0] r_result;

    function automatic logic [XLEN-1:0] f_word_ext(input logic word, input logic [XLEN-1:0] v);
        return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Operand decode for the capture edge
    logic            w_is_unsigned;
    logic            w_is_rem;
    logic            w_is_word;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_min_neg;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_result;
    logic            w_start;

    assign w_is_unsigned = i_riscv_div_ctrl[0];
    assign w_is_rem      = i_riscv_div_ctrl[1];
    assign w_is_word     = i_riscv_div_ctrl[2];

    assign w_op_a = !w_is_word     ? i_riscv_div_rs1data :
                    w_is_unsigned  ? {{(XLEN-32){1'b0}}, i_riscv_div_rs1data[31:0]} :
                                     {{(XLEN-32){i_riscv_div_rs1data[31]}}, i_riscv_div_rs1data[31:0]};
    assign w_op_b = !w_is_word     ? i_riscv_div_rs2data :
                    w_is_unsigned  ? {{(XLEN-32){1'b0}}, i_riscv_div_rs2data[31:0]} :
                                     {{(XLEN-32){i_riscv_div_rs2data[31]}}, i_riscv_div_rs2data[31:0]};

    assign w_a_neg = !w_is_unsigned && w_op_a[XLEN-1];
    assign w_b_neg = !w_is_unsigned && w_op_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_op_a : w_op_a;
    assign w_b_mag = w_b_neg ? -w_op_b : w_op_b;

    assign w_min_neg  = w_is_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = (w_op_b == '0);
    assign w_ovf      = !w_is_unsigned && (w_op_b == '1) && (w_op_a == w_min_neg);
    assign w_special  = w_div_zero || w_ovf;

    assign w_special_result = f_word_ext(w_is_word,
                                w_div_zero ? (w_is_rem ? w_op_a : '1)
                                           : (w_is_rem ? '0     : w_op_a));

    assign w_start = (r_state == S_IDLE) && i_riscv_div_en && !i_riscv_div_kill;

    // One restoring step: shift in the next dividend bit, keep the difference if it fits
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_take;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_final;

    assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
    assign w_take      = (w_rem_shift >= {1'b0, r_divisor});
    assign w_diff      = w_rem_shift[XLEN-1:0] - r_divisor;
    assign w_rem_next  = w_take ? w_diff : w_rem_shift[XLEN-1:0];
    assign w_quo_next  = {r_quo[XLEN-2:0], w_take};

    assign w_q_fix = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_r_fix = r_neg_r ? -w_rem_next : w_rem_next;
    assign w_final = f_word_ext(r_word, r_rem_sel ? w_r_fix : w_q_fix);

    // NOTE: every output of a combinational block is assigned a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next_state = w_special ? S_DONE : S_CALC;
            S_CALC: begin
                if (i_riscv_div_kill || !i_riscv_div_en) w_next_state = S_IDLE;
                else if (r_cnt == CW'(1))                w_next_state = S_DONE;
            end
            S_DONE: if (i_riscv_div_kill || !i_riscv_div_stallother) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_riscv_div_clk) begin
        if (i_riscv_div_rst) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_word    <= 1'b0;
            r_rem_sel <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_word    <= w_is_word;
                r_rem_sel <= w_is_rem;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_divisor <= w_b_mag;
                r_rem     <= '0;
                // Word dividends sit in the top half so the MSB shifted out is always bit XLEN-1
                r_quo     <= w_is_word ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
                r_cnt     <= w_is_word ? N_WORD : N_FULL;
                if (w_special) r_result <= w_special_result;
            end else if (r_state == S_CALC && i_riscv_div_en && !i_riscv_div_kill) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) r_result <= w_final;
            end
        end
    end

    assign o_riscv_div_result = r_result;
    assign o_riscv_div_valid  = (r_state == S_DONE);
    assign o_riscv_div_busy   = (r_state == S_CALC);

endmodule
